// File: rtl/line_clear_sequencer.sv
// line_clear_sequencer: piece phase controller (spawn, spawn check, fall,
// lock) plus bottom-up two-pointer row compaction over a single-row
// read/write port into the fixed-state board.
// Optional scoring is built when LINE_CLEAR_SCORE_EN is defined; otherwise
// score is tied to zero.
module line_clear_sequencer #(
  parameter int WIDTH   = 10,
  parameter int HEIGHT  = 20,
  parameter int COUNT_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      game_tick,
  input  logic                      piece_touching_bottom,
  input  logic                      spawn_blocked,
  output logic [$clog2(HEIGHT)-1:0] row_rd_idx,
  input  logic [WIDTH-1:0]          row_rd_data,
  output logic                      row_wr_en,
  output logic [$clog2(HEIGHT)-1:0] row_wr_idx,
  output logic [WIDTH-1:0]          row_wr_data,
  output logic                      insert_new_piece,
  output logic                      lock_piece,
  output logic                      gravity_en,
  output logic                      clearing_line,
  output logic                      game_over,
  output logic [COUNT_W-1:0]        lines_cleared,
  output logic [23:0]               score
);

  localparam int IDX_W = $clog2(HEIGHT);
  localparam int K_W   = $clog2(HEIGHT + 1);
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(HEIGHT - 1);

  typedef enum logic [2:0] {
    S_SPAWN,
    S_SPAWN_CHK,
    S_FALL,
    S_LOCK,
    S_COMPACT,
    S_FILL,
    S_GAMEOVER
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   r_q, r_d;
  logic [IDX_W-1:0]   w_q, w_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [COUNT_W-1:0] lc_q, lc_d;
  logic [COUNT_W:0]   lc_sum;
  logic               row_full;
  logic               compact_exit;

  assign row_full      = &row_rd_data;
  assign lines_cleared = lc_q;

  // State and pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_SPAWN;
      r_q     <= '0;
      w_q     <= '0;
      k_q     <= '0;
      lc_q    <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      w_q     <= w_d;
      k_q     <= k_d;
      lc_q    <= lc_d;
    end
  end

  // Next-state, pointer update and output decode; outputs are forced idle
  // while reset is high so the reset cycle never strobes or writes.
  always_comb begin
    state_d          = state_q;
    r_d              = r_q;
    w_d              = w_q;
    k_d              = k_q;
    lc_d             = lc_q;
    lc_sum           = '0;
    compact_exit     = 1'b0;
    row_rd_idx       = '0;
    row_wr_en        = 1'b0;
    row_wr_idx       = '0;
    row_wr_data      = '0;
    insert_new_piece = 1'b0;
    lock_piece       = 1'b0;
    gravity_en       = 1'b0;
    clearing_line    = 1'b0;
    game_over        = 1'b0;

    unique case (state_q)
      S_SPAWN: begin
        insert_new_piece = 1'b1;
        state_d          = S_SPAWN_CHK;
      end
      S_SPAWN_CHK: begin
        state_d = spawn_blocked ? S_GAMEOVER : S_FALL;
      end
      S_FALL: begin
        gravity_en = 1'b1;
        if (game_tick && piece_touching_bottom) state_d = S_LOCK;
      end
      S_LOCK: begin
        lock_piece = 1'b1;
        r_d        = LAST_ROW;
        w_d        = LAST_ROW;
        k_d        = '0;
        state_d    = S_COMPACT;
      end
      S_COMPACT: begin
        clearing_line = 1'b1;
        row_rd_idx    = r_q;
        if (row_full) begin
          k_d = k_q + 1'b1;
        end else begin
          if (w_q != r_q) begin
            row_wr_en   = 1'b1;
            row_wr_idx  = w_q;
            row_wr_data = row_rd_data;
          end
          w_d = w_q - 1'b1;
        end
        r_d = r_q - 1'b1;
        if (r_q == '0) begin
          compact_exit = 1'b1;
          state_d      = (k_d != '0) ? S_FILL : S_SPAWN;
        end
      end
      S_FILL: begin
        clearing_line = 1'b1;
        row_wr_en     = 1'b1;
        row_wr_idx    = w_q;
        row_wr_data   = '0;
        w_d           = w_q - 1'b1;
        if (w_q == '0) state_d = S_SPAWN;
      end
      S_GAMEOVER: begin
        game_over = 1'b1;
      end
      default: begin
        state_d = S_SPAWN;
      end
    endcase

    // Saturating running total, using k including the exit cycle's row
    lc_sum = {1'b0, lc_q} + (COUNT_W + 1)'(k_d);
    if (compact_exit) lc_d = lc_sum[COUNT_W] ? '1 : lc_sum[COUNT_W-1:0];

    if (reset) begin
      row_rd_idx       = '0;
      row_wr_en        = 1'b0;
      row_wr_idx       = '0;
      row_wr_data      = '0;
      insert_new_piece = 1'b0;
      lock_piece       = 1'b0;
      gravity_en       = 1'b0;
      clearing_line    = 1'b0;
      game_over        = 1'b0;
    end
  end

`ifdef LINE_CLEAR_SCORE_EN
  logic [23:0] score_q, score_d, score_inc;
  logic [24:0] score_sum;

  // Score increment by number of rows removed in this compaction
  always_comb begin
    score_inc = '0;
    score_sum = '0;
    score_d   = score_q;
    if (k_d == '0)               score_inc = 24'd0;
    else if (k_d == K_W'(1))     score_inc = 24'd40;
    else if (k_d == K_W'(2))     score_inc = 24'd100;
    else if (k_d == K_W'(3))     score_inc = 24'd300;
    else                         score_inc = 24'd1200;
    score_sum = {1'b0, score_q} + {1'b0, score_inc};
    if (compact_exit) score_d = score_sum[24] ? '1 : score_sum[23:0];
  end

  // Score register
  always_ff @(posedge clk) begin
    if (reset) score_q <= '0;
    else       score_q <= score_d;
  end

  assign score = score_q;
`else
  assign score = '0;
`endif

endmodule

// File: tb/tb_line_clear_sequencer.sv
// Self-checking bench for line_clear_sequencer: behavioural board memory,
// scoreboard of expected board contents / counters per lock event.
`timescale 1ns/1ps
module tb_line_clear_sequencer;

  localparam int WIDTH   = 10;
  localparam int HEIGHT  = 20;
  localparam int COUNT_W = 16;
  localparam int IDX_W   = $clog2(HEIGHT);

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               game_tick = 1'b0;
  logic               piece_touching_bottom = 1'b0;
  logic               spawn_blocked = 1'b0;
  logic [IDX_W-1:0]   row_rd_idx;
  logic [WIDTH-1:0]   row_rd_data;
  logic               row_wr_en;
  logic [IDX_W-1:0]   row_wr_idx;
  logic [WIDTH-1:0]   row_wr_data;
  logic               insert_new_piece, lock_piece, gravity_en;
  logic               clearing_line, game_over;
  logic [COUNT_W-1:0] lines_cleared;
  logic [23:0]        score;

  logic [WIDTH-1:0] board      [HEIGHT];
  logic [WIDTH-1:0] board_init [HEIGHT];
  logic             load_all = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0]   exp_row_q [$];
  int                 exp_clr_q [$];
  logic [COUNT_W-1:0] exp_lc_q  [$];
  logic [23:0]        exp_sc_q  [$];
  int                 model_lc = 0;
  int                 model_sc = 0;

  line_clear_sequencer #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .COUNT_W(COUNT_W)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .game_tick            (game_tick),
    .piece_touching_bottom(piece_touching_bottom),
    .spawn_blocked        (spawn_blocked),
    .row_rd_idx           (row_rd_idx),
    .row_rd_data          (row_rd_data),
    .row_wr_en            (row_wr_en),
    .row_wr_idx           (row_wr_idx),
    .row_wr_data          (row_wr_data),
    .insert_new_piece     (insert_new_piece),
    .lock_piece           (lock_piece),
    .gravity_en           (gravity_en),
    .clearing_line        (clearing_line),
    .game_over            (game_over),
    .lines_cleared        (lines_cleared),
    .score                (score)
  );

  always #5 clk = ~clk;

  assign row_rd_data = board[row_rd_idx];

  always @(posedge clk) begin
    if (load_all) board <= board_init;
    else if (row_wr_en) board[row_wr_idx] <= row_wr_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // Fill board_init: rows in full_mask are all ones, others are distinct
  // non-full patterns (bit 0 clear), or all zeros when empty is set.
  task automatic set_pattern(input logic [HEIGHT-1:0] full_mask, input int seed, input bit empty);
    for (int i = 0; i < HEIGHT; i++) begin
      if (full_mask[i])  board_init[i] = '1;
      else if (empty)    board_init[i] = '0;
      else               board_init[i] = {(WIDTH-1)'((i + 1) * 23 + seed), 1'b0};
    end
    @(negedge clk);
    load_all = 1'b1;
    @(negedge clk);
    load_all = 1'b0;
  endtask

  // Reference: keep non-full rows in bottom-up order, stack them at the
  // bottom and pad the top with empty rows.
  task automatic push_expect();
    logic [WIDTH-1:0] kept [$];
    int k;
    int inc;
    kept.delete();
    for (int i = HEIGHT - 1; i >= 0; i--)
      if (board_init[i] !== '1) kept.push_back(board_init[i]);
    k = HEIGHT - kept.size();
    for (int row = 0; row < HEIGHT; row++) begin
      int j;
      j = HEIGHT - 1 - row;
      exp_row_q.push_back((j < kept.size()) ? kept[j] : '0);
    end
    exp_clr_q.push_back(HEIGHT + k);
    model_lc = model_lc + k;
    if (model_lc > (1 << COUNT_W) - 1) model_lc = (1 << COUNT_W) - 1;
    exp_lc_q.push_back(COUNT_W'(model_lc));
`ifdef LINE_CLEAR_SCORE_EN
    case (k)
      0:       inc = 0;
      1:       inc = 40;
      2:       inc = 100;
      3:       inc = 300;
      default: inc = 1200;
    endcase
`else
    inc = 0;
    model_sc = 0;
`endif
    model_sc = model_sc + inc;
    if (model_sc > 24'hFFFFFF) model_sc = 24'hFFFFFF;
    exp_sc_q.push_back(24'(model_sc));
  endtask

  // From SPAWN, wait for the FALL phase.
  task automatic wait_fall(input string name);
    bit seen;
    seen = 1'b0;
    spawn_blocked = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (gravity_en) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s wait_fall: gravity_en got 0 want 1 within 10 cycles", name);
    end
  endtask

  // Lock the piece from FALL and follow the compaction to the next SPAWN,
  // then compare against the scoreboard entry.
  task automatic run_lock(input string name, input bit want_no_writes);
    int clr, wr, extra_lock;
    bit seen;
    clr = 0; wr = 0; extra_lock = 0; seen = 1'b0;
    game_tick = 1'b1;
    piece_touching_bottom = 1'b1;
    @(negedge clk);
    n_checks++;
    if (lock_piece !== 1'b1) begin
      n_fail++;
      $display("FAIL %s lock_pulse: got %b want 1", name, lock_piece);
    end
    game_tick = 1'b0;
    piece_touching_bottom = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (insert_new_piece) seen = 1'b1;
      else begin
        if (clearing_line) clr++;
        if (row_wr_en)     wr++;
        if (lock_piece)    extra_lock++;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s spawn_timeout: insert_new_piece got 0 want 1 within 200 cycles", name);
    end
    begin
      int ec;
      logic [COUNT_W-1:0] el;
      logic [23:0] es;
      ec = exp_clr_q.pop_front();
      el = exp_lc_q.pop_front();
      es = exp_sc_q.pop_front();
      n_checks++;
      if (clr !== ec) begin
        n_fail++;
        $display("FAIL %s clear_cycles: got %0d want %0d", name, clr, ec);
      end
      n_checks++;
      if (lines_cleared !== el) begin
        n_fail++;
        $display("FAIL %s lines_cleared: got %0d want %0d", name, lines_cleared, el);
      end
      n_checks++;
      if (score !== es) begin
        n_fail++;
        $display("FAIL %s score: got %0d want %0d", name, score, es);
      end
    end
    n_checks++;
    if (extra_lock !== 0) begin
      n_fail++;
      $display("FAIL %s lock_len: extra lock cycles got %0d want 0", name, extra_lock);
    end
    if (want_no_writes) begin
      n_checks++;
      if (wr !== 0) begin
        n_fail++;
        $display("FAIL %s no_writes: row_wr_en cycles got %0d want 0", name, wr);
      end
    end
    for (int row = 0; row < HEIGHT; row++) begin
      logic [WIDTH-1:0] er;
      er = exp_row_q.pop_front();
      n_checks++;
      if (board[row] !== er) begin
        n_fail++;
        $display("FAIL %s row%0d: got %h want %h", name, row, board[row], er);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_pattern('0, 0, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({insert_new_piece, lock_piece, gravity_en, clearing_line, game_over, row_wr_en} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 000000",
               {insert_new_piece, lock_piece, gravity_en, clearing_line, game_over, row_wr_en});
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (insert_new_piece !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_spawn: insert_new_piece got %b want 1", insert_new_piece);
    end
    n_checks++;
    if ({lines_cleared, score, row_rd_idx, row_wr_idx, row_wr_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: lc %0d score %0d rd %0d wr %0d wd %h want all 0",
               lines_cleared, score, row_rd_idx, row_wr_idx, row_wr_data);
    end
    @(negedge clk);
    n_checks++;
    if ({insert_new_piece, gravity_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL spawn_chk: insert/gravity got %b want 00", {insert_new_piece, gravity_en});
    end
    wait_fall("reset");
  endtask

  task automatic test_empty_board();
    // Touching without a tick, and a tick without touching, must not lock
    piece_touching_bottom = 1'b1;
    repeat (3) @(negedge clk);
    piece_touching_bottom = 1'b0;
    game_tick = 1'b1;
    @(negedge clk);
    game_tick = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({gravity_en, lock_piece} !== 2'b10) begin
      n_fail++;
      $display("FAIL fall_hold: gravity/lock got %b want 10", {gravity_en, lock_piece});
    end
    set_pattern('0, 0, 1'b1);
    push_expect();
    run_lock("empty", 1'b1);
    wait_fall("empty");
  endtask

  task automatic test_one_row();
    set_pattern(20'h80000, 3, 1'b0);
    push_expect();
    run_lock("one_row", 1'b0);
    wait_fall("one_row");
  endtask

  task automatic test_two_rows();
    set_pattern(20'hA0000, 7, 1'b0);
    push_expect();
    run_lock("two_rows", 1'b0);
    wait_fall("two_rows");
  endtask

  task automatic test_four_rows();
    set_pattern(20'hF0000, 11, 1'b0);
    push_expect();
    run_lock("four_rows", 1'b0);
  endtask

  // Entered at the SPAWN cycle following the four-row compaction
  task automatic test_gameover();
    spawn_blocked = 1'b1;
    @(negedge clk);
    n_checks++;
    if (game_over !== 1'b0) begin
      n_fail++;
      $display("FAIL gameover_early: got %b want 0", game_over);
    end
    @(negedge clk);
    n_checks++;
    if (game_over !== 1'b1) begin
      n_fail++;
      $display("FAIL gameover_set: got %b want 1", game_over);
    end
    spawn_blocked = 1'b0;
    game_tick = 1'b1;
    piece_touching_bottom = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if ({game_over, gravity_en, lock_piece, insert_new_piece, clearing_line, row_wr_en} !== 6'b100000) begin
        n_fail++;
        $display("FAIL gameover_sticky: got %b want 100000",
                 {game_over, gravity_en, lock_piece, insert_new_piece, clearing_line, row_wr_en});
      end
    end
    game_tick = 1'b0;
    piece_touching_bottom = 1'b0;
  endtask

  task automatic test_reset_mid_compact();
    int clr;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_lc = 0;
    model_sc = 0;
    @(negedge clk);
    n_checks++;
    if ({game_over, lines_cleared, score} !== '0) begin
      n_fail++;
      $display("FAIL reset_clears: go %b lc %0d score %0d want 0", game_over, lines_cleared, score);
    end
    wait_fall("reset_mid");
    set_pattern(20'h80000, 5, 1'b0);
    // Four COMPACT cycles run: row 19 dropped, rows 18..16 moved down one
    for (int row = 0; row < HEIGHT; row++)
      exp_row_q.push_back((row >= 17) ? board_init[row - 1] : board_init[row]);
    game_tick = 1'b1;
    piece_touching_bottom = 1'b1;
    @(negedge clk);
    game_tick = 1'b0;
    piece_touching_bottom = 1'b0;
    clr = 0;
    for (int c = 0; c < 10 && clr < 5; c++) begin
      @(negedge clk);
      if (clearing_line) clr++;
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({row_wr_en, clearing_line} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_cycle_gate: wr_en/clearing got %b want 00", {row_wr_en, clearing_line});
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({insert_new_piece, clearing_line, row_wr_en} !== 3'b100 || lines_cleared !== '0) begin
      n_fail++;
      $display("FAIL reset_abort: ins/clr/wr got %b lc %0d want 100 lc 0",
               {insert_new_piece, clearing_line, row_wr_en}, lines_cleared);
    end
    for (int row = 0; row < HEIGHT; row++) begin
      logic [WIDTH-1:0] er;
      er = exp_row_q.pop_front();
      n_checks++;
      if (board[row] !== er) begin
        n_fail++;
        $display("FAIL reset_mid row%0d: got %h want %h", row, board[row], er);
      end
    end
  endtask

  initial begin
    test_reset();
    test_empty_board();
    test_one_row();
    test_two_rows();
    test_four_rows();
    test_gameover();
    test_reset_mid_compact();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/line_clear_sequencer.md
Name: line_clear_sequencer

Overview:
- Phase controller for the game datapath. Sequences each piece: spawn, spawn check, gravity fall, lock into the fixed state, then row compaction.
- Drives the insert-new-piece, lock and clearing-line controls that the game executioner consumes.
- Owns a single-row read/write port into the fixed-state board. Full rows are removed by a bottom-up two-pointer compaction, one row per cycle.
- Sits between the game executioner and the fixed-state storage; clocked on the system clock.

Parameters:
- WIDTH, 10, board columns; a row is full when all WIDTH bits are 1.
- HEIGHT, 20, board rows; row 0 is the top, row HEIGHT-1 is the bottom.
- COUNT_W, 16, width of the lines_cleared counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- game_tick  input  1  one-cycle pulse per gravity step.
- piece_touching_bottom  input  1  active piece rests on the floor or on fixed cells.
- spawn_blocked  input  1  newly inserted piece overlaps fixed cells.
- row_rd_idx  output  $clog2(HEIGHT)  row address for combinational read.
- row_rd_data  input  WIDTH  contents of row row_rd_idx, valid in the same cycle.
- row_wr_en  output  1  write strobe for row_wr_idx.
- row_wr_idx  output  $clog2(HEIGHT)  row write address.
- row_wr_data  output  WIDTH  row write data.
- insert_new_piece  output  1  one-cycle pulse: load new piece, reset y.
- lock_piece  output  1  one-cycle pulse: merge active piece into the fixed state.
- gravity_en  output  1  high while the piece may fall.
- clearing_line  output  1  high during compaction and fill.
- game_over  output  1  sticky until reset.
- lines_cleared  output  COUNT_W  running total of cleared rows.
- score  output  24  see Optional Feature.

Behaviour:
- Reset values:
  - State goes to SPAWN.
  - All pulse and strobe outputs are 0; gravity_en, clearing_line and game_over are 0.
  - lines_cleared and score are 0; internal pointers are 0.
  - No row writes occur in the reset cycle.
- Reset mid-operation aborts any in-progress compaction; partially compacted rows are left as written.
- States:
  - SPAWN: insert_new_piece=1 for one cycle -> SPAWN_CHK.
  - SPAWN_CHK: if spawn_blocked -> GAMEOVER, else -> FALL.
  - FALL: gravity_en=1. On a cycle with game_tick and piece_touching_bottom both high -> LOCK. Touching without a tick stays in FALL.
  - LOCK: lock_piece=1 for one cycle. On entry, r=HEIGHT-1, w=HEIGHT-1, k=0 -> COMPACT.
  - COMPACT: clearing_line=1, row_rd_idx=r.
    - If row_rd_data is all ones: k++, w unchanged.
    - Otherwise: if w!=r, write row_rd_data to row w (row_wr_en=1, row_wr_idx=w). In all non-full cases w--.
    - r-- every cycle. The cycle that processes r==0 exits: to FILL if k>0 (counting this cycle), else to SPAWN.
  - FILL: clearing_line=1. Write zeros to row w each cycle, w--. The cycle that writes row 0 -> SPAWN.
  - GAMEOVER: terminal. All pulses, gravity_en and clearing_line are 0; game_over=1. Exit only by reset.
- Latency from LOCK to SPAWN: HEIGHT+k cycles.
- No row writes occur outside COMPACT/FILL.
- lines_cleared += k on the cycle COMPACT exits; saturates at 2^COUNT_W-1.
- game_tick pulses outside FALL are ignored.
- When idle, row_rd_idx=0, row_wr_idx=0 and row_wr_data=0.

Optional Feature:
- Macro: LINE_CLEAR_SCORE_EN.
- Defined: on COMPACT exit, score adds 40, 100, 300 or 1200 for k = 1, 2, 3 or 4. k>4 adds 1200. k=0 adds 0. score saturates at 2^24-1.
- Undefined: score is tied to 0 and the scoring logic is absent.

Test Plan:
- Reset, then an empty board -> insert_new_piece pulses in the cycle after reset releases. After SPAWN_CHK, gravity_en=1.
- Empty board, touching + tick -> lock_piece for 1 cycle, then clearing_line high exactly 20 cycles. row_wr_en never asserts; lines_cleared stays 0; insert_new_piece follows.
- Row 19 full, rows 0-18 have distinct patterns -> rows 19..1 receive old rows 18..0 and row 0 receives 0. clearing_line lasts 21 cycles; lines_cleared=1; score=40 with the macro defined.
- Rows 17 and 19 full -> 22 clearing cycles; final rows 19..2 hold old rows 18, 16..0; rows 1 and 0 are zero. lines_cleared=2, score=100.
- Rows 16-19 full -> score=1200, lines_cleared=4. A subsequent spawn with spawn_blocked=1 -> game_over=1 two cycles after entering SPAWN; the machine then ignores game_tick.
- Assert reset on the 5th COMPACT cycle -> the next cycle has row_wr_en=0 and clearing_line=0; state is SPAWN; lines_cleared=0.
